// File: rtl/pipeline_hazard_controller_pkg.sv
`default_nettype none
// ============================================================================
// pipeline_hazard_controller_pkg : opcodes, sequencer state encoding, rt-use decode
// Revision: 1.0
// ============================================================================
package pipeline_hazard_controller_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_HALT  = 6'b111111;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } state_e;

    // Instructions that read rt as a source (immediates write rt instead).
    function automatic logic uses_rt(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_BEQ) || (op == OP_BNE) || (op == OP_SW);
    endfunction

endpackage
`default_nettype wire

// File: rtl/pipeline_hazard_controller_sat_counter.sv
`default_nettype none
// ============================================================================
// sat_counter : WIDTH-bit up counter, optionally saturating at all-ones
// Revision: 1.0
// ============================================================================
module sat_counter #(
    parameter int WIDTH    = 16,
    parameter bit SATURATE = 1'b1
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             en_i,
    output logic [WIDTH-1:0] count_o
);

    logic [WIDTH-1:0] count_q;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            count_q <= '0;
        end else if (en_i && !(SATURATE && (&count_q))) begin
            count_q <= count_q + WIDTH'(1);
        end
    end

    assign count_o = count_q;

endmodule
`default_nettype wire

// File: rtl/pipeline_hazard_controller.sv
`default_nettype none
// ============================================================================
// pipeline_hazard_controller : load-use stall, branch flush, single-step and
// HALT drain sequencing for the 5-stage pipeline.  Revision: 1.0
// ============================================================================
module pipeline_hazard_controller
    import pipeline_hazard_controller_pkg::*;
#(
    parameter int         CNT_W        = 16,
    parameter int         DRAIN_CYCLES = 3,
    parameter logic [5:0] HALT_OP      = OP_HALT
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic [5:0]       id_opcode_i,
    input  logic [4:0]       id_rs_i,
    input  logic [4:0]       id_rt_i,
    input  logic             ex_mem_read_i,
    input  logic [4:0]       ex_rt_i,
    input  logic             branch_taken_i,
    input  logic             step_mode_i,
    input  logic             step_req_i,
    output logic             pipe_en_o,
    output logic             pc_write_o,
    output logic             if_id_write_o,
    output logic             if_id_flush_o,
    output logic             id_ex_bubble_o,
    output logic             halted_o,
    output logic [CNT_W-1:0] stall_count_o,
    output logic [CNT_W-1:0] cycle_count_o
);

    localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    state_e        state_q, state_d;
    logic [DW-1:0] drain_cnt_q, drain_cnt_d;
    logic          w_en, w_lu_hazard, w_stall_inc, w_cycle_inc;
    logic          w_pipe_en, w_pc_write, w_if_id_write, w_flush, w_bubble, w_halted;

    assign w_en        = !step_mode_i || step_req_i;
    assign w_lu_hazard = ex_mem_read_i && (ex_rt_i != 5'd0) &&
                         ((ex_rt_i == id_rs_i) || (uses_rt(id_opcode_i) && (ex_rt_i == id_rt_i)));

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q     <= RUN;
            drain_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            drain_cnt_q <= drain_cnt_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        drain_cnt_d   = drain_cnt_q;
        w_pipe_en     = 1'b0;
        w_pc_write    = 1'b0;
        w_if_id_write = 1'b0;
        w_flush       = 1'b0;
        w_bubble      = 1'b0;
        w_halted      = 1'b0;
        w_stall_inc   = 1'b0;
        w_cycle_inc   = 1'b0;
        case (state_q)
            RUN: begin
                w_pipe_en   = w_en;
                w_cycle_inc = w_en;
                if (w_en) begin
                    // A taken branch under a load-use stall is re-evaluated next cycle.
                    if (w_lu_hazard) begin
                        w_bubble    = 1'b1;
                        w_stall_inc = 1'b1;
                    end else if (id_opcode_i == HALT_OP) begin
                        w_bubble    = 1'b1;
                        state_d     = DRAIN;
                        drain_cnt_d = DW'(DRAIN_CYCLES - 1);
                    end else begin
                        w_pc_write    = 1'b1;
                        w_if_id_write = 1'b1;
                        w_flush       = branch_taken_i;
                    end
                end
            end
            DRAIN: begin
                w_pipe_en   = w_en;
                w_cycle_inc = w_en;
                if (w_en) begin
                    w_bubble = 1'b1;
                    if (drain_cnt_q == '0) begin
                        state_d = HALTED;
                    end else begin
                        drain_cnt_d = drain_cnt_q - DW'(1);
                    end
                end
            end
            HALTED: begin
                w_halted = 1'b1;
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    // Outputs are forced low while reset is held, independent of the clock.
    assign pipe_en_o      = w_pipe_en     && !reset_i;
    assign pc_write_o     = w_pc_write    && !reset_i;
    assign if_id_write_o  = w_if_id_write && !reset_i;
    assign if_id_flush_o  = w_flush       && !reset_i;
    assign id_ex_bubble_o = w_bubble      && !reset_i;
    assign halted_o       = w_halted      && !reset_i;

    sat_counter #(.WIDTH(CNT_W), .SATURATE(1'b1)) u_stall_cnt (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .en_i    (w_stall_inc),
        .count_o (stall_count_o)
    );

    sat_counter #(.WIDTH(CNT_W), .SATURATE(1'b0)) u_cycle_cnt (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .en_i    (w_cycle_inc),
        .count_o (cycle_count_o)
    );

endmodule
`default_nettype wire

// File: doc/pipeline_hazard_controller.md
Name: pipeline_hazard_controller

Overview:
- Sequences the 5-stage MIPS pipeline around the ID-stage control decoder.
- Generates stall, bubble and flush strobes for load-use hazards and taken branches.
- Gates the pipeline for single-step debug and drains the pipeline on a HALT opcode.
- Sits in ID, next to the control decoder. Its outputs drive PC, IF/ID and ID/EX register enables and clears, and feed the debug unit.

Parameters:
- CNT_W, 16: width of the stall_count and cycle_count counters.
- DRAIN_CYCLES, 3: enabled cycles held in DRAIN after HALT leaves ID, so older instructions complete WB.
- HALT_OP, 6'b111111: opcode that triggers halt.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- id_opcode  in  6  opcode of the instruction in IF/ID.
- id_rs  in  5  rs field of the instruction in IF/ID.
- id_rt  in  5  rt field of the instruction in IF/ID.
- ex_mem_read  in  1  ID/EX holds a load (M_control[1]).
- ex_rt  in  5  destination rt of the instruction in ID/EX.
- branch_taken  in  1  branch in ID resolved taken this cycle.
- step_mode  in  1  1 = pipeline advances only on step_req.
- step_req  in  1  one-cycle pulse: advance one cycle.
- pipe_en  out  1  global pipeline register enable.
- pc_write  out  1  PC load enable.
- if_id_write  out  1  IF/ID load enable.
- if_id_flush  out  1  clear IF/ID to NOP on this edge.
- id_ex_bubble  out  1  zero the control fields loaded into ID/EX.
- halted  out  1  pipeline stopped after HALT.
- stall_count  out  CNT_W  number of load-use stall cycles.
- cycle_count  out  CNT_W  number of enabled cycles since reset.

Behaviour:
- State register: RUN, DRAIN, HALTED. Counter drain_cnt. All are async-cleared by reset to RUN, drain_cnt=0, counters=0.
- While reset is high, all outputs are 0.
- Outputs are combinational from state and inputs; there is no added latency.
- en = !step_mode | step_req. In RUN and DRAIN, pipe_en=en. In HALTED, pipe_en=0.
- If en=0 or state is HALTED: pc_write, if_id_write, if_id_flush and id_ex_bubble are all 0. State and counters hold.
- uses_rt = 1 for opcode 000000, 000100, 000101 and 101011; otherwise 0.
- lu_hazard = ex_mem_read & (ex_rt!=0) & ((ex_rt==id_rs) | (uses_rt & ex_rt==id_rt)).
- RUN with en=1, resolved by priority:
  1. lu_hazard: pc_write=0, if_id_write=0, id_ex_bubble=1, if_id_flush=0 (a taken branch is suppressed and re-evaluated next cycle). stall_count increments, saturating at all-ones.
  2. id_opcode==HALT_OP: pc_write=0, if_id_write=0, id_ex_bubble=1. Go to DRAIN with drain_cnt=DRAIN_CYCLES-1.
  3. branch_taken: pc_write=1, if_id_write=1, if_id_flush=1, id_ex_bubble=0.
  4. Otherwise: pc_write=1, if_id_write=1, if_id_flush=0, id_ex_bubble=0.
- DRAIN with en=1: pc_write=0, if_id_write=0, id_ex_bubble=1, if_id_flush=0.
  - drain_cnt==0 → go to HALTED.
  - Otherwise drain_cnt decrements.
  - Hazard and branch inputs are ignored.
- HALTED: halted=1. Leaves only via reset.
- cycle_count increments on every en=1 cycle in RUN or DRAIN and wraps modulo 2^CNT_W.
- Reset asserted mid-DRAIN or mid-stall: immediate return to RUN; counters cleared.
- step_req while step_mode=0: no extra effect.
- step_req held high for multiple cycles: one advance per cycle it is high.

Decomposition:
- Shared package (also used by control_unit): opcode constants OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_HALT; state encoding RUN=2'd0, DRAIN=2'd1, HALTED=2'd2.
- One natural sub-module: sat_counter (CNT_W-bit, enable, optional saturate). Instantiate it twice: saturating for stall_count, wrapping for cycle_count.

Test Plan:
- Load-use: ex_mem_read=1, ex_rt=5, id_opcode=000000, id_rs=5 → pc_write=0, if_id_write=0, id_ex_bubble=1 for exactly 1 cycle; stall_count 0→1.
- rt rule for immediates: ex_rt=7, id_rt=7, id_rs=3, id_opcode=001000 (ADDI) → no stall. With id_opcode=000100 (BEQ) → stall. With ex_rt=0 → never stall.
- Branch:
  - branch_taken=1, no hazard → if_id_flush=1, pc_write=1.
  - branch_taken=1 with lu_hazard=1 → flush=0, stall asserted.
- Halt: id_opcode=6'b111111 in RUN, step_mode=0 → bubble for 1+3 cycles. halted=1 on the 4th edge after HALT was in ID. pipe_en=0 thereafter; cycle_count frozen.
- Step mode: step_mode=1 with 3 step_req pulses over 10 cycles → pipe_en high exactly 3 cycles; cycle_count=3; all write enables 0 on the other 7 cycles.
- Reset mid-DRAIN: assert reset asynchronously between edges → all outputs 0 immediately. After release: state RUN, halted=0, counters=0.
